// File: rtl/gh_if.sv
// Fetch/resolve bundle between the front end and the global-history manager.
// master drives fetch/resolve requests; slave is the history manager.
interface gh_if #(
  parameter int gh_width   = 14,
  parameter int bh_width   = 14,
  parameter int ADDR_WIDTH = 29,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] pc;
  logic                  pdc_valid;
  logic                  taken_pdc;
  logic                  pdc_ready;
  logic [gh_width-1:0]   pc_gh_hashed;
  logic [bh_width-1:0]   pc_bh_hashed;
  logic                  ex_valid;
  logic [ADDR_WIDTH-1:0] pc_ex;
  logic                  taken_real;
  logic                  mispredict_ex;
  logic                  flush;
  logic [gh_width-1:0]   pc_ex_gh_hashed;
  logic [bh_width-1:0]   pc_ex_bh_hashed;
  logic [CW-1:0]         count;

  modport master (
    output pc, pdc_valid, taken_pdc, ex_valid, pc_ex, taken_real, mispredict_ex, flush,
    input  pdc_ready, pc_gh_hashed, pc_bh_hashed, pc_ex_gh_hashed, pc_ex_bh_hashed, count
  );

  modport slave (
    input  pc, pdc_valid, taken_pdc, ex_valid, pc_ex, taken_real, mispredict_ex, flush,
    output pdc_ready, pc_gh_hashed, pc_bh_hashed, pc_ex_gh_hashed, pc_ex_bh_hashed, count
  );
endinterface

// File: rtl/gh_manager.sv
// Speculative global-history manager: GHR, fetch/EX hashed indices, and an
// in-order checkpoint queue used to repair history on mispredict or flush.
module gh_manager #(
  parameter int gh_width   = 14,
  parameter int bh_width   = 14,
  parameter int ADDR_WIDTH = 29,
  parameter int DEPTH      = 8
) (
  input logic clk,
  input logic rst,
  gh_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [gh_width-1:0] ghr;
  logic [gh_width-1:0] arch_ghr;
  logic [gh_width-1:0] arch_next;
  logic [gh_width-1:0] head_ckpt;
  logic [gh_width-1:0] ckpt [DEPTH];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;
  logic                empty;
  logic                ready;
  logic                push;
  logic                pop;
  logic                mis;

  function automatic logic [gh_width-1:0] shift(input logic [gh_width-1:0] v, input logic b);
    return {v[gh_width-2:0], b};
  endfunction

  assign empty     = (count == '0);
  assign ready     = (count != CW'(DEPTH));
  assign head_ckpt = ckpt[head];

  assign pop  = bus.ex_valid && !empty;
  assign mis  = pop && bus.mispredict_ex;
  // A mispredict resolving this cycle drops the push even when nothing pops.
  assign push = bus.pdc_valid && ready && !bus.flush && !(bus.ex_valid && bus.mispredict_ex);

  assign arch_next = pop ? shift(arch_ghr, bus.taken_real) : arch_ghr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr      <= '0;
      arch_ghr <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      arch_ghr <= arch_next;
      if (bus.flush) begin
        ghr   <= arch_next;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (mis) begin
        ghr   <= shift(head_ckpt, bus.taken_real);
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          ghr  <= shift(ghr, bus.taken_pdc);
          tail <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Checkpoint storage needs no reset: entries are only read while count != 0.
  always_ff @(posedge clk) begin
    if (push) ckpt[tail] <= ghr;
  end

  assign bus.pdc_ready       = ready;
  assign bus.count           = count;
  assign bus.pc_gh_hashed    = bus.pc[gh_width-1:0] ^ ghr;
  assign bus.pc_bh_hashed    = bus.pc[bh_width-1:0] ^ bus.pc[2*bh_width-1:bh_width];
  assign bus.pc_ex_gh_hashed = empty ? '0 : (bus.pc_ex[gh_width-1:0] ^ head_ckpt);
  assign bus.pc_ex_bh_hashed = bus.pc_ex[bh_width-1:0] ^ bus.pc_ex[2*bh_width-1:bh_width];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc, bus.pc_ex};
endmodule

// File: tb/tb_gh_manager.sv
// Scoreboard bench for gh_manager: directed hand-computed vectors followed by
// a randomized stream checked against a queue-based reference model.
module tb_gh_manager;
  localparam int GW = 4;
  localparam int BW = 4;
  localparam int AW = 12;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gh_if #(.gh_width(GW), .bh_width(BW), .ADDR_WIDTH(AW), .DEPTH(D)) bus ();
  gh_manager #(.gh_width(GW), .bh_width(BW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string    name;
    logic [3:0] gh;
    logic [3:0] bh;
    logic [3:0] exh;
    logic [3:0] exbh;
    logic [2:0] cnt;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  logic [3:0] m_ghr;
  logic [3:0] m_arch;
  logic [3:0] m_q[$];

  function automatic logic [3:0] fold(input logic [AW-1:0] a);
    return a[3:0] ^ a[7:4];
  endfunction

  function automatic logic [3:0] sh(input logic [3:0] v, input logic b);
    return {v[2:0], b};
  endfunction

  task automatic chk(input string n, input string f, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk(e.name, "pc_gh_hashed",    bus.pc_gh_hashed,    e.gh);
        chk(e.name, "pc_bh_hashed",    bus.pc_bh_hashed,    e.bh);
        chk(e.name, "pc_ex_gh_hashed", bus.pc_ex_gh_hashed, e.exh);
        chk(e.name, "pc_ex_bh_hashed", bus.pc_ex_bh_hashed, e.exbh);
        chk(e.name, "count",           {1'b0, bus.count},   {1'b0, e.cnt});
        chk(e.name, "pdc_ready",       {3'b0, bus.pdc_ready}, {3'b0, e.rdy});
      end
    end
  end

  task automatic drive(input logic [AW-1:0] pc, input logic pv, input logic tp, input logic ex,
                       input logic [AW-1:0] pcex, input logic tr, input logic mis, input logic fl);
    bus.pc            = pc;
    bus.pdc_valid     = pv;
    bus.taken_pdc     = tp;
    bus.ex_valid      = ex;
    bus.pc_ex         = pcex;
    bus.taken_real    = tr;
    bus.mispredict_ex = mis;
    bus.flush         = fl;
  endtask

  // Directed step with hand-computed gh/exh/count/ready for this cycle.
  task automatic hand(input string n, input logic [AW-1:0] pc, input logic pv, input logic tp,
                      input logic ex, input logic [AW-1:0] pcex, input logic tr, input logic mis,
                      input logic fl, input logic [3:0] gh, input logic [3:0] exh,
                      input logic [2:0] cnt, input logic rdy, input logic arst);
    exp_t e;
    drive(pc, pv, tp, ex, pcex, tr, mis, fl);
    e.name = n; e.gh = gh; e.bh = fold(pc); e.exh = exh; e.exbh = fold(pcex);
    e.cnt = cnt; e.rdy = rdy;
    sb.push_back(e);
    if (arst) begin
      #2 rst = 1'b1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_reset();
    drive('0, 0, 0, 0, '0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_ghr = '0;
    m_arch = '0;
    m_q.delete();
  endtask

  task automatic rnd_step(input logic [AW-1:0] pc, input logic pv, input logic tp, input logic ex,
                          input logic [AW-1:0] pcex, input logic tr, input logic mis, input logic fl);
    exp_t e;
    logic pop, push;
    logic [3:0] arch_n, head;
    drive(pc, pv, tp, ex, pcex, tr, mis, fl);
    head = (m_q.size() != 0) ? m_q[0] : 4'h0;
    e.name = "rnd"; e.gh = pc[3:0] ^ m_ghr; e.bh = fold(pc);
    e.exh = (m_q.size() != 0) ? (pcex[3:0] ^ head) : 4'h0;
    e.exbh = fold(pcex); e.cnt = 3'(m_q.size()); e.rdy = (m_q.size() != D);
    sb.push_back(e);
    pop  = ex && (m_q.size() != 0);
    push = pv && (m_q.size() != D) && !fl && !(ex && mis);
    arch_n = pop ? sh(m_arch, tr) : m_arch;
    m_arch = arch_n;
    if (fl) begin
      m_ghr = arch_n;
      m_q.delete();
    end else if (pop && mis) begin
      m_ghr = sh(head, tr);
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(m_ghr);
        m_ghr = sh(m_ghr, tp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive('0, 0, 0, 0, '0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values, then async reset mid-cycle with two entries in flight.
    hand("rst0",  12'h005, 0, 0, 0, 12'h000, 0, 0, 0, 4'h5, 4'h0, 3'd0, 1, 0);
    hand("pre1",  12'h000, 1, 1, 0, 12'h000, 0, 0, 0, 4'h0, 4'h0, 3'd0, 1, 0);
    hand("pre2",  12'h000, 1, 1, 0, 12'h000, 0, 0, 0, 4'h1, 4'h0, 3'd1, 1, 0);
    hand("arst",  12'h005, 0, 0, 0, 12'h000, 0, 0, 0, 4'h5, 4'h0, 3'd0, 1, 1);

    // Fill: T,T,N,T then a fifth prediction is refused.
    hand("push1", 12'h000, 1, 1, 0, 12'h000, 0, 0, 0, 4'h0, 4'h0, 3'd0, 1, 0);
    hand("push2", 12'h000, 1, 1, 0, 12'h000, 0, 0, 0, 4'h1, 4'h0, 3'd1, 1, 0);
    hand("push3", 12'h000, 1, 0, 0, 12'h000, 0, 0, 0, 4'h3, 4'h0, 3'd2, 1, 0);
    hand("push4", 12'h000, 1, 1, 0, 12'h000, 0, 0, 0, 4'h6, 4'h0, 3'd3, 1, 0);
    hand("push5", 12'h000, 1, 1, 0, 12'h000, 0, 0, 0, 4'hD, 4'h0, 3'd4, 0, 0);
    hand("full",  12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 4'hD, 4'h0, 3'd4, 0, 0);

    // Correct resolve of head, then mispredict of checkpoint 0x1 with a dropped push.
    hand("res1",  12'h000, 0, 0, 1, 12'h002, 1, 0, 0, 4'hD, 4'h2, 3'd4, 0, 0);
    hand("mis",   12'h000, 1, 1, 1, 12'h000, 0, 1, 0, 4'hD, 4'h1, 3'd3, 1, 0);
    hand("aftmis",12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 4'h2, 4'h0, 3'd0, 1, 0);

    // Resolve against an empty queue changes nothing.
    hand("exemp", 12'h000, 0, 0, 1, 12'h007, 1, 1, 0, 4'h2, 4'h0, 3'd0, 1, 0);
    hand("chkemp",12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 4'h2, 4'h0, 3'd0, 1, 0);

    // Build arch_ghr=0x3 with pop+push cycles (tail wraps past entry 3), then flush.
    do_reset();
    hand("f_p1",  12'h000, 1, 1, 0, 12'h000, 0, 0, 0, 4'h0, 4'h0, 3'd0, 1, 0);
    hand("f_p2",  12'h000, 1, 1, 0, 12'h000, 0, 0, 0, 4'h1, 4'h0, 3'd1, 1, 0);
    hand("f_pp1", 12'h000, 1, 0, 1, 12'h000, 1, 0, 0, 4'h3, 4'h0, 3'd2, 1, 0);
    hand("f_pp2", 12'h000, 1, 1, 1, 12'h000, 1, 0, 0, 4'h6, 4'h1, 3'd2, 1, 0);
    hand("flush1",12'h000, 1, 1, 0, 12'h000, 0, 0, 1, 4'hD, 4'h3, 3'd2, 1, 0);
    hand("aftfl", 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 4'h3, 4'h0, 3'd0, 1, 0);
    hand("f2_p",  12'h000, 1, 0, 0, 12'h000, 0, 0, 0, 4'h3, 4'h0, 3'd0, 1, 0);
    hand("f2_fl", 12'h000, 0, 0, 1, 12'h090, 1, 0, 1, 4'h6, 4'h3, 3'd1, 1, 0);
    hand("aft2",  12'h035, 0, 0, 0, 12'h000, 0, 0, 0, 4'h2, 4'h0, 3'd0, 1, 0);

    // Random stream against the reference model.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      rnd_step(12'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 2) == 0),
               12'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0));
    end
    drive('0, 0, 0, 0, '0, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gh_manager.md
# gh_manager

Speculative global-history manager feeding the direction predictor. Holds the speculative global history register (GHR), forms the fetch-side hashed indices from the fetch PC, and keeps an in-order checkpoint queue of in-flight conditional-branch predictions. At resolve time it supplies the EX-side hashed index and repairs history on mispredict or flush.

## Interface
- `gh_width`, default 14: GHR width and gh-hash width.
- `bh_width`, default 14: bh-hash width; requires `ADDR_WIDTH >= 2*bh_width`.
- `ADDR_WIDTH`, default 29: PC width (word address).
- `DEPTH`, default 8: checkpoint queue entries; power of two, at least 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high (one clock; reset is asynchronous and active-high).
- `pc`  in  ADDR_WIDTH  fetch PC.
- `pdc_valid`  in  1  a conditional-branch prediction (DIRECT_JUMP/OTHER_JUMP) is issued this cycle.
- `taken_pdc`  in  1  predicted direction for that branch.
- `pdc_ready`  out  1  queue can accept a prediction; fetch stalls conditional branches while low.
- `pc_gh_hashed`  out  gh_width  `pc[gh_width-1:0] ^ ghr`.
- `pc_bh_hashed`  out  bh_width  `pc[bh_width-1:0] ^ pc[2*bh_width-1:bh_width]`.
- `ex_valid`  in  1  oldest in-flight conditional branch resolves this cycle.
- `pc_ex`  in  ADDR_WIDTH  PC of the resolving branch.
- `taken_real`  in  1  actual direction.
- `mispredict_ex`  in  1  direction mispredicted; qualified by `ex_valid`.
- `flush`  in  1  non-branch redirect (exception, ertn, refetch).
- `pc_ex_gh_hashed`  out  gh_width  `pc_ex[gh_width-1:0] ^ head_ckpt`; 0 when the queue is empty.
- `pc_ex_bh_hashed`  out  bh_width  same fold as `pc_bh_hashed`, applied to `pc_ex`.
- `count`  out  $clog2(DEPTH)+1  occupancy.

## Operation
- State: speculative `ghr`, architectural `arch_ghr`, queue of `DEPTH` entries (each holds the `ghr` value before its shift), head/tail pointers, occupancy `count`.
- Shift rule: `new = {old[gh_width-2:0], bit}`, with the newest outcome in bit 0.
- Push: `pdc_valid && pdc_ready && !flush && !(ex_valid && mispredict_ex)`. Write the current `ghr` at the tail; `ghr <= shift(ghr, taken_pdc)`; advance the tail.
- Pop: `ex_valid && count!=0`. Advance the head; `arch_ghr <= shift(arch_ghr, taken_real)`.
- `ex_valid` with an empty queue: ignored. No state changes and `pc_ex_gh_hashed` is 0.
- Mispredict (pop with `mispredict_ex`):
  - `ghr <= shift(head_ckpt, taken_real)`.
  - Queue cleared (count 0, head=tail=0).
  - Any same-cycle push is dropped.
- Flush:
  - `ghr <=` the post-update `arch_ghr`, including any same-cycle pop.
  - Queue cleared; the push is dropped.
- Priority: `rst` > `flush` > mispredict > normal push/pop.
- Push and pop together with no mispredict: count unchanged and both pointers advance.
- Pointers wrap modulo `DEPTH`.
- `pdc_ready = (count != DEPTH)`. It is registered-state only and does not depend on a same-cycle pop.
- Reset: `ghr=0`, `arch_ghr=0`, pointers 0, `count=0`, so `pdc_ready=1`, `pc_gh_hashed=pc[gh_width-1:0]`, and `pc_ex_gh_hashed=0`.
- Reset mid-operation discards all in-flight entries immediately.

## Timing
- All hash outputs are combinational from registered state plus the current PC inputs. There is zero-cycle latency to the predictor tables.
- A shift from a push is visible on `pc_gh_hashed` in the cycle after `pdc_valid`.
- Repair from mispredict or flush is visible the cycle after the event. Fetch redirects in that same cycle.
- `pc_ex_gh_hashed` is valid in the `ex_valid` cycle and reflects the head entry before the pop.
- `count` and `pdc_ready` update on the clock edge after a push or pop.

## Test plan
Bench parameters: `gh_width=4`, `DEPTH=4`.
- Reset, then `pc=0x5`: `pc_gh_hashed=0x5`, `pdc_ready=1`, `count=0`. Assert `rst` asynchronously mid-cycle: outputs return to these values before the next edge.
- Push taken, taken, not-taken, taken: `ghr` goes 0x1, 0x3, 0x6, 0xD; `count=4`, `pdc_ready=0`. A fifth `pdc_valid` is ignored and `ghr` stays 0xD.
- From that state, resolve the head correctly with `pc_ex=0x2`, taken: `pc_ex_gh_hashed=0x2` (checkpoint 0x0). Next cycle `arch_ghr=0x1`, `count=3`, `pdc_ready=1`. Pop plus push in one cycle keeps `count` constant; pointers wrap past entry 3 correctly.
- Second branch (checkpoint 0x1) resolves mispredicted with `taken_real=0`: next cycle `ghr=0x2`, `count=0`. A same-cycle `pdc_valid` is dropped.
- `flush` with `arch_ghr=0x3` and 2 entries queued: next cycle `ghr=0x3`, `count=0`. `flush` together with a correct pop of a taken branch: `ghr=0x7`.
- `ex_valid` with an empty queue: no state change and `pc_ex_gh_hashed=0`.
- Random push/resolve/flush stream checked against a reference model for `ghr`, `arch_ghr` and `count` over 10k cycles.
